// File: rtl/tournament_sched4.sv
// -----------------------------------------------------------------------------
// tournament_sched4
//
// Four-requester grant scheduler for a shared resource, such as a BRAM port or
// a functional unit. Each round first snapshots the pending requests and their
// keys. A base-4 minimum-key tournament then picks the owner, which gets a
// registered one-hot grant. The grant is held until the owner reports done,
// drops its request, or runs out of burst budget. One dead cycle (RELEASE)
// follows every grant so ownership changes never overlap on the bus.
//
// Optional feature macro: TOURNAMENT_SCHED_AGING_EN
//   When defined, each requester gets a saturating age counter. A saturated
//   requester outranks every unsaturated one, so high-key requesters cannot
//   starve. When undefined, arbitration is purely by minimum key.
//
// Parameters:
//   WIDTH_KEY  request key width (smaller key wins)
//   AGE_WIDTH  per-requester age counter width (only meaningful with aging)
//   MAX_BURST  maximum number of GRANT cycles before a forced release (>= 1)
//
// Ports:
//   clock      system clock
//   reset      asynchronous, active-high reset
//   I_Req      per-requester request, level-held until served
//   I_Key0..3  per-requester key
//   I_Done     current owner finished (only looked at while granting)
//   O_Grant    registered one-hot grant
//   O_Winner   index of the current / most recent winner
//   O_Key      raw key of the winner
//   O_Busy     high while a round is in progress (ARB, GRANT, RELEASE)
//   O_Timeout  one-cycle pulse during RELEASE after a forced release
// -----------------------------------------------------------------------------
module tournament_sched4 #(
    parameter int WIDTH_KEY = 8,
    parameter int AGE_WIDTH = 3,
    parameter int MAX_BURST = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [3:0]           I_Req,
    input  logic [WIDTH_KEY-1:0] I_Key0,
    input  logic [WIDTH_KEY-1:0] I_Key1,
    input  logic [WIDTH_KEY-1:0] I_Key2,
    input  logic [WIDTH_KEY-1:0] I_Key3,
    input  logic                 I_Done,
    output logic [3:0]           O_Grant,
    output logic [1:0]           O_Winner,
    output logic [WIDTH_KEY-1:0] O_Key,
    output logic                 O_Busy,
    output logic                 O_Timeout
);

    // The burst counter has one spare bit, so the terminal count always fits
    // and the counter can never wrap back to zero while a grant is held.
    localparam int CNT_W = $clog2(MAX_BURST) + 1;
    localparam int EFF_W = WIDTH_KEY + 2;
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARB,
        ST_GRANT,
        ST_RELEASE
    } state_t;

    state_t state;
    state_t state_next;

    // Snapshot of the requests and keys taken on the IDLE -> ARB edge
    logic [3:0]                 snap_req;
    logic [3:0][WIDTH_KEY-1:0]  snap_key;

    logic [CNT_W-1:0]           burst_cnt;
    logic                       burst_last;

    logic [3:0][AGE_WIDTH-1:0]  age;
    logic [3:0]                 sat;

    // Effective tournament entries and the select tree
    logic [3:0][EFF_W-1:0]      eff;
    logic [1:0]                 pair10_idx;
    logic [1:0]                 pair32_idx;
    logic [1:0]                 final_idx;
    logic [EFF_W-1:0]           pair10_key;
    logic [EFF_W-1:0]           pair32_key;

    // Build the effective key of each entry. The two prefix bits sit above the
    // raw key, so they dominate the comparison. A non-requester has a leading
    // 1 and always loses. A saturated requester has a 0 in the second bit and
    // so beats any unsaturated requester, whatever the raw keys are.
    always_comb begin
        sat = '0;
        eff = '0;
        for (int i = 0; i < 4; i++) begin
            sat[i] = &age[i];
            eff[i] = {~snap_req[i], ~sat[i], snap_key[i]};
        end
    end

    // Two-level select tree over the snapshot. Every compare is strict
    // less-than, and the lower-indexed side is the default. That makes ties
    // resolve to the lowest index at both levels of the tree.
    always_comb begin
        pair10_idx = 2'd0;
        pair10_key = eff[0];
        if (eff[1] < eff[0]) begin
            pair10_idx = 2'd1;
            pair10_key = eff[1];
        end

        pair32_idx = 2'd2;
        pair32_key = eff[2];
        if (eff[3] < eff[2]) begin
            pair32_idx = 2'd3;
            pair32_key = eff[3];
        end

        final_idx = pair10_idx;
        if (pair32_key < pair10_key) begin
            final_idx = pair32_idx;
        end
    end

    assign burst_last = (burst_cnt == BURST_LAST);

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. GRANT ends on the first of three conditions: the
    // owner reports done, the owner withdraws its request, or the burst
    // budget runs out.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (|I_Req) begin
                    state_next = ST_ARB;
                end
            end
            ST_ARB: begin
                state_next = ST_GRANT;
            end
            ST_GRANT: begin
                if (I_Done || !I_Req[O_Winner] || burst_last) begin
                    state_next = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign O_Busy = (state != ST_IDLE);

    // Datapath registers: the snapshot, the registered grant outputs and the
    // burst counter. O_Timeout is cleared by default each cycle. It is set
    // only on the GRANT -> RELEASE edge, and only when the budget ran out;
    // that still holds if I_Done arrives on the same final cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            snap_req  <= '0;
            snap_key  <= '0;
            burst_cnt <= '0;
            O_Grant   <= '0;
            O_Winner  <= '0;
            O_Key     <= '0;
            O_Timeout <= 1'b0;
        end else begin
            O_Timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|I_Req) begin
                        snap_req <= I_Req;
                        snap_key <= {I_Key3, I_Key2, I_Key1, I_Key0};
                    end
                end
                ST_ARB: begin
                    O_Grant   <= 4'b0001 << final_idx;
                    O_Winner  <= final_idx;
                    O_Key     <= snap_key[final_idx];
                    burst_cnt <= '0;
                end
                ST_GRANT: begin
                    if (state_next == ST_RELEASE) begin
                        O_Grant   <= '0;
                        O_Timeout <= burst_last;
                    end else begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef TOURNAMENT_SCHED_AGING_EN
    // Age counters are updated once per round, on the ARB -> GRANT edge.
    // Every requester in the snapshot that lost gets one step older, up to
    // saturation. The winner and anyone not requesting start over at zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            age <= '0;
        end else if (state == ST_ARB) begin
            for (int i = 0; i < 4; i++) begin
                if (snap_req[i] && (final_idx != 2'(i))) begin
                    if (!sat[i]) begin
                        age[i] <= age[i] + 1'b1;
                    end
                end else begin
                    age[i] <= '0;
                end
            end
        end
    end
`else
    // Aging compiled out: the ages are constant zero, so no entry is ever
    // saturated and the tournament is a pure minimum-key choice.
    always_comb begin
        age = '0;
    end
`endif

endmodule
